async_req_arbiter: RTL

//  Round-robin arbiter granting one shared resource to NREQ requesters in foreign clock domains.

---
 rtl/arb_pkg.sv | 16 +
 rtl/async_req_arbiter_rr_pick.sv | 36 +++
 rtl/async_req_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and limits for the asynchronous-request round-robin arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam int ARB_RANK_MIN = 2;
    localparam int ARB_RANK_MAX = 4;
    localparam int ARB_NREQ_MIN = 2;
    localparam int ARB_NREQ_MAX = 16;

endpackage

// File: rtl/async_req_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting one
// position above the last winner, wrapping modulo NREQ, and reports the first
// set bit as a valid flag, a one-hot vector and a binary index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last_gnt,
    output logic            o_valid,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx
);

    // Rotating priority scan; the first hit freezes all three outputs.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        logic          hit;
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        cand     = 0;
        cand_idx = '0;
        hit      = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(i_last_gnt) + k) % NREQ;
            cand_idx = IW'(cand);
            hit      = !o_valid && i_req[cand_idx];
            o_onehot = hit ? (NREQ'(1) << cand_idx) : o_onehot;
            o_idx    = hit ? cand_idx : o_idx;
            o_valid  = o_valid | hit;
        end
    end

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter handing a single-owner resource to NREQ requesters that
// live in foreign clock domains. Requests are synchronised through a RANK-deep
// flop chain, one winner is granted, the resource is kicked with a one-cycle
// res_start pulse, and the transaction closes with a 4-phase req/ack handshake.
// Optional BUSY watchdog: define ARB_TIMEOUT_EN to enable it; otherwise BUSY
// waits for res_done indefinitely and o_err_tmo is tied low.
module async_req_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int RANK    = 2,
    parameter int TMO_CYC = 200
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req_async,
    output logic [NREQ-1:0]         o_ack,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_gnt_id,
    output logic                    o_res_start,
    input  logic                    i_res_done,
    output logic                    o_busy,
    output logic                    o_err_tmo
);

    localparam int IW        = $clog2(NREQ);
    localparam int SYNC_TAIL = (RANK >= ARB_RANK_MIN) ? (RANK - 1) : 1;

    // Elaboration-time parameter legality checks.
    if (RANK < ARB_RANK_MIN || RANK > ARB_RANK_MAX) begin : g_bad_rank
        $error("async_req_arbiter: RANK=%0d outside legal range 2..4", RANK);
    end
    if (NREQ < ARB_NREQ_MIN || NREQ > ARB_NREQ_MAX) begin : g_bad_nreq
        $error("async_req_arbiter: NREQ=%0d outside legal range 2..16", NREQ);
    end
    if (TMO_CYC < 1) begin : g_bad_tmo
        $error("async_req_arbiter: TMO_CYC=%0d must be at least 1", TMO_CYC);
    end

    // ------------------------------------------------------------------
    // Request synchroniser: first stage tagged for the place-and-route
    // tools so it is kept adjacent to the second stage.
    // ------------------------------------------------------------------
    (* ASYNC_REG = "TRUE" *) logic [NREQ-1:0] r_sync_s1;
    logic [NREQ-1:0] r_sync_tail [SYNC_TAIL];
    logic [NREQ-1:0] w_req_s;

    // Plain flop chain; reset clears every stage so no stale request survives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_s1 <= '0;
            for (int i = 0; i < SYNC_TAIL; i++) begin
                r_sync_tail[i] <= '0;
            end
        end else begin
            r_sync_s1      <= i_req_async;
            r_sync_tail[0] <= r_sync_s1;
            for (int i = 1; i < SYNC_TAIL; i++) begin
                r_sync_tail[i] <= r_sync_tail[i-1];
            end
        end
    end

    assign w_req_s = r_sync_tail[SYNC_TAIL-1];

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // ------------------------------------------------------------------
    logic [IW-1:0]   r_last_gnt;
    logic            w_pick_valid;
    logic [NREQ-1:0] w_pick_onehot;
    logic [IW-1:0]   w_pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req      (w_req_s),
        .i_last_gnt (r_last_gnt),
        .o_valid    (w_pick_valid),
        .o_onehot   (w_pick_onehot),
        .o_idx      (w_pick_idx)
    );

    // ------------------------------------------------------------------
    // Transaction FSM and registered outputs
    // ------------------------------------------------------------------
    arb_state_t      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_gnt_id;
    logic [NREQ-1:0] r_ack;
    logic            r_res_start;
    logic            r_busy;

`ifdef ARB_TIMEOUT_EN
    localparam int            TW       = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_err_tmo;
`endif

    // IDLE->START->BUSY->ACK sequencing; every output is a flop updated here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_ack       <= '0;
            r_res_start <= 1'b0;
            r_busy      <= 1'b0;
            r_last_gnt  <= IW'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_err_tmo   <= 1'b0;
`endif
        end else begin
            r_res_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state  <= START;
                        r_gnt    <= w_pick_onehot;
                        r_gnt_id <= w_pick_idx;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                START: begin
                    // res_done is deliberately not looked at here.
                    r_state     <= BUSY;
                    r_res_start <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    r_tmo_cnt   <= '0;
`endif
                end
                BUSY: begin
                    if (i_res_done) begin
                        r_state <= ACK;
                        r_ack   <= r_gnt;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        // Resource hung: release the requester and flag it.
                        r_state   <= ACK;
                        r_ack     <= r_gnt;
                        r_err_tmo <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
`else
                    else begin
                        r_state <= BUSY;
                    end
`endif
                end
                ACK: begin
                    if (!w_req_s[r_gnt_id]) begin
                        r_state    <= IDLE;
                        r_ack      <= '0;
                        r_gnt      <= '0;
                        r_busy     <= 1'b0;
                        r_last_gnt <= r_gnt_id;
                    end else begin
                        r_state    <= ACK;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_gnt       = r_gnt;
    assign o_gnt_id    = r_gnt_id;
    assign o_res_start = r_res_start;
    assign o_busy      = r_busy;
`ifdef ARB_TIMEOUT_EN
    assign o_err_tmo   = r_err_tmo;
`else
    assign o_err_tmo   = 1'b0;
`endif

endmodule
